// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame layout and the baud divider formula
// used by both uart_tx and uart_rx.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } uart_state_e;

  localparam int unsigned FRAME_DATA_BITS = 8;
  localparam logic        START_BIT       = 1'b0;
  localparam logic        STOP_BIT        = 1'b1;

  // Clocks per bit, truncated.
  function automatic int unsigned calc_cpb(input int unsigned f, input int unsigned baud);
    return f / baud;
  endfunction

  function automatic int unsigned calc_half(input int unsigned cpb);
    return cpb / 2;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input; resets to ResetVal so an
// idle-high line reads idle straight out of reset.
module uart_sync #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= ResetVal;
      q    <= ResetVal;
    end else begin
      s1_q <= d;
      q    <= s1_q;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: centre-samples each bit, emits a one-cycle valid strobe per good byte
// and a one-cycle frame_err strobe when the stop bit reads 0.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD = 115200,
  parameter int unsigned F    = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CPB  = calc_cpb(F, BAUD);
  localparam int unsigned HALF = calc_half(CPB);
  localparam int unsigned CntW = $clog2(CPB);
  localparam int unsigned IdxW = $clog2(FRAME_DATA_BITS);

  localparam logic [CntW-1:0] CntHalf = CntW'(HALF - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(CPB - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(FRAME_DATA_BITS - 1);

  if (CPB < 4) begin : gen_cpb_check
    $error("uart_rx: F/BAUD must be at least 4");
  end

  logic                       rx_s;
  logic                       rx_q;
  uart_state_e                state_q;
  logic [CntW-1:0]            cnt_q;
  logic [IdxW-1:0]            idx_q;
  logic [FRAME_DATA_BITS-1:0] shift_q;

  uart_sync #(
    .ResetVal(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q      <= 1'b1;
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_q      <= rx_s;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      cnt_q     <= cnt_q + 1'b1;
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          // Edge, not level: a line stuck low must not retrigger.
          if (rx_s == START_BIT && rx_q != START_BIT) begin
            state_q <= StStart;
            busy    <= 1'b1;
          end
        end
        StStart: begin
          if (cnt_q == CntHalf) begin
            cnt_q <= '0;
            if (rx_s == START_BIT) begin
              state_q <= StData;
              idx_q   <= '0;
            end else begin
              state_q <= StIdle;
              busy    <= 1'b0;
            end
          end
        end
        StData: begin
          if (cnt_q == CntFull) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[FRAME_DATA_BITS-1:1]};
            idx_q   <= idx_q + 1'b1;
            if (idx_q == IdxLast) begin
              state_q <= StStop;
            end
          end
        end
        StStop: begin
          // Returning to idle on the sample itself leaves room for a back-to-back start edge.
          if (cnt_q == CntFull) begin
            cnt_q   <= '0;
            state_q <= StIdle;
            busy    <= 1'b0;
            if (rx_s == STOP_BIT) begin
              data  <= shift_q;
              valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at F=1000, BAUD=100 (10 clocks per bit, half-bit 5).
module tb_uart_rx;

  localparam int unsigned F    = 1000;
  localparam int unsigned BAUD = 100;
  localparam int          CPB  = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int         v_cyc[$];
  logic [7:0] v_dat[$];
  int         fe_cyc[$];
  int         both    = 0;
  int         win_lo  = 0;
  int         win_hi  = -1;
  int         busy_hi = 0;
  int         busy_lo = 0;

  uart_rx #(
    .BAUD(BAUD),
    .F   (F)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // cyc here equals the index of the posedge that produced the sampled outputs.
  always @(negedge clk) begin
    if (valid) begin
      v_cyc.push_back(cyc);
      v_dat.push_back(data);
    end
    if (frame_err) fe_cyc.push_back(cyc);
    if (valid && frame_err) both = both + 1;
    if (cyc >= win_lo && cyc <= win_hi) begin
      if (busy) busy_hi = busy_hi + 1;
      else busy_lo = busy_lo + 1;
    end
  end

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // t0 is the posedge that first captures the start bit in the first sync flop.
  task automatic send_frame(input logic [7:0] b, input logic stop, output int t0);
    t0 = cyc + 1;
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    hold(stop, CPB);
  endtask

  task automatic clear_log();
    v_cyc.delete();
    v_dat.delete();
    fe_cyc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    checks++;
    if (valid !== 1'b0 || frame_err !== 1'b0) begin
      failures++; $display("FAIL reset_strobes: got valid=%b frame_err=%b expected 0 0", valid, frame_err);
    end
    checks++;
    if (data !== 8'h00) begin
      failures++; $display("FAIL reset_data: got %h expected 00", data);
    end
    rst = 1'b0;
    hold(1'b1, 5);
  endtask

  task automatic test_single_byte();
    int t0;
    clear_log();
    send_frame(8'hA5, 1'b1, t0);
    hold(1'b1, 5);
    checks++;
    if (v_cyc.size() !== 1) begin
      failures++; $display("FAIL single_valid_count: got %0d expected 1", v_cyc.size());
    end else begin
      checks++;
      if (v_cyc[0] !== t0 + 97) begin
        failures++; $display("FAIL single_valid_cycle: got %0d expected %0d", v_cyc[0] - t0, 97);
      end
      checks++;
      if (v_dat[0] !== 8'hA5) begin
        failures++; $display("FAIL single_data: got %h expected a5", v_dat[0]);
      end
    end
    checks++;
    if (fe_cyc.size() !== 0) begin
      failures++; $display("FAIL single_frame_err: got %0d pulses expected 0", fe_cyc.size());
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    int t1;
    int t2;
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h00;
    exp_d[1] = 8'hFF;
    exp_d[2] = 8'h55;
    clear_log();
    win_lo  = cyc + 3;
    win_hi  = cyc + 297;
    busy_hi = 0;
    busy_lo = 0;
    send_frame(exp_d[0], 1'b1, t0);
    send_frame(exp_d[1], 1'b1, t1);
    send_frame(exp_d[2], 1'b1, t2);
    hold(1'b1, 5);
    win_hi = -1;
    checks++;
    if (v_cyc.size() !== 3) begin
      failures++; $display("FAIL b2b_valid_count: got %0d expected 3", v_cyc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (v_cyc[i] !== t0 + 97 + 100 * i || v_dat[i] !== exp_d[i]) begin
          failures++;
          $display("FAIL b2b_frame%0d: got cycle %0d data %h expected cycle %0d data %h",
                   i, v_cyc[i] - t0, v_dat[i], 97 + 100 * i, exp_d[i]);
        end
      end
    end
    checks++;
    if (busy_lo !== 10) begin
      failures++; $display("FAIL b2b_busy_low: got %0d cycles expected 10", busy_lo);
    end
  endtask

  task automatic test_framing_error();
    int t0;
    int t1;
    clear_log();
    send_frame(8'h3C, 1'b0, t0);
    checks++;
    if (fe_cyc.size() !== 1 || v_cyc.size() !== 0) begin
      failures++;
      $display("FAIL ferr_pulses: got frame_err=%0d valid=%0d expected 1 0", fe_cyc.size(), v_cyc.size());
    end else begin
      checks++;
      if (fe_cyc[0] !== t0 + 97) begin
        failures++; $display("FAIL ferr_cycle: got %0d expected 97", fe_cyc[0] - t0);
      end
    end
    checks++;
    if (data !== 8'h55) begin
      failures++; $display("FAIL ferr_data_held: got %h expected 55", data);
    end
    hold(1'b0, 200);
    hold(1'b1, 20);
    checks++;
    if (fe_cyc.size() !== 1 || v_cyc.size() !== 0) begin
      failures++;
      $display("FAIL ferr_held_low: got frame_err=%0d valid=%0d expected 1 0", fe_cyc.size(), v_cyc.size());
    end
    send_frame(8'h12, 1'b1, t1);
    hold(1'b1, 5);
    checks++;
    if (v_cyc.size() !== 1) begin
      failures++; $display("FAIL ferr_recover_count: got %0d expected 1", v_cyc.size());
    end else begin
      checks++;
      if (v_cyc[0] !== t1 + 97 || v_dat[0] !== 8'h12) begin
        failures++;
        $display("FAIL ferr_recover: got cycle %0d data %h expected 97 12", v_cyc[0] - t1, v_dat[0]);
      end
    end
  endtask

  task automatic test_glitch();
    int t0;
    clear_log();
    t0      = cyc + 1;
    win_lo  = t0;
    win_hi  = t0 + 20;
    busy_hi = 0;
    busy_lo = 0;
    hold(1'b0, 3);
    hold(1'b1, 25);
    win_hi = -1;
    checks++;
    if (busy_hi !== 5 || busy_lo !== 16) begin
      failures++; $display("FAIL glitch_busy: got hi=%0d lo=%0d expected 5 16", busy_hi, busy_lo);
    end
    checks++;
    if (v_cyc.size() !== 0 || fe_cyc.size() !== 0) begin
      failures++;
      $display("FAIL glitch_strobes: got valid=%0d frame_err=%0d expected 0 0", v_cyc.size(), fe_cyc.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    int t1;
    logic [7:0] b;
    b = 8'h81;
    clear_log();
    hold(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(b[i], CPB);
    hold(b[4], 5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || data !== 8'h00) begin
      failures++; $display("FAIL midrst_state: got busy=%b data=%h expected 0 00", busy, data);
    end
    rst = 1'b0;
    hold(1'b1, 20);
    checks++;
    if (v_cyc.size() !== 0 || fe_cyc.size() !== 0) begin
      failures++;
      $display("FAIL midrst_strobes: got valid=%0d frame_err=%0d expected 0 0", v_cyc.size(), fe_cyc.size());
    end
    send_frame(8'h7E, 1'b1, t1);
    hold(1'b1, 5);
    checks++;
    if (v_cyc.size() !== 1) begin
      failures++; $display("FAIL midrst_recover_count: got %0d expected 1", v_cyc.size());
    end else begin
      checks++;
      if (v_cyc[0] !== t1 + 97 || v_dat[0] !== 8'h7E) begin
        failures++;
        $display("FAIL midrst_recover: got cycle %0d data %h expected 97 7e", v_cyc[0] - t1, v_dat[0]);
      end
    end
  endtask

  task automatic test_bytes();
    int t0;
    logic [7:0] vec [3];
    vec[0] = 8'h41;
    vec[1] = 8'h80;
    vec[2] = 8'h01;
    for (int i = 0; i < 3; i++) begin
      clear_log();
      send_frame(vec[i], 1'b1, t0);
      hold(1'b1, 3);
      checks++;
      if (v_cyc.size() !== 1 || data !== vec[i]) begin
        failures++;
        $display("FAIL byte_%0d: got %0d pulses data %h expected 1 %h", i, v_cyc.size(), data, vec[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_framing_error();
    test_glitch();
    test_reset_mid_frame();
    test_bytes();
    checks++;
    if (both !== 0) begin
      failures++; $display("FAIL exclusive_strobes: got %0d overlaps expected 0", both);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
